display_scheduler: RTL and testbench
====================================

// Module: display_scheduler
// PURPOSE
//  Shares the 4-digit 7-segment display between three sources and feeds d1..d4 of the display driver.
//  Src0 is the always-valid background, e.g. the credit readout.
//  Src1 (price) and src2 (status text, e.g. SOLD/ERR) are one-shot messages.
//  A message is latched on a request pulse and shown for a fixed hold time, optionally blinking.
//  The display then returns to src0.
// PARAMETERS
//  HOLD_T      2000   message display time, in tick periods (>=1)
//  BLINK_T     250    half-period of blink, in tick periods (>=1)
//  BLANK_CODE  4'hF   nibble driven on all digits during blink-off phase
// PORTS
//  clk         in   1   system clock
//  clr         in   1   asynchronous reset, active-high
//  tick        in   1   one-clk-wide timebase enable (1 kHz strobe)
//  bg_val      in   16  src0 digits {d1,d2,d3,d4}, sampled every cycle
//  req1        in   1   src1 request pulse; msg1/blink1 captured on this cycle
//  msg1        in   16  src1 digits
//  blink1      in   1   src1 message blinks when 1
//  req2        in   1   src2 request pulse; msg2/blink2 captured on this cycle
//  msg2        in   16  src2 digits
//  blink2      in   1   src2 message blinks when 1
//  d1,d2,d3,d4 out  4   registered digit nibbles to display driver
//  active_src  out  2   0=bg, 1=src1, 2=src2 currently displayed
//  busy        out  1   1 while a message is shown or pending
// BEHAVIOUR
//  Reset (clr high, async): d1..d4=0, active_src=0, busy=0, state=IDLE, pending flags cleared.
//  All outputs are registered; one-clk latency from sampled input to output.
//  States:
//    IDLE   outputs = bg_val.
//    SHOW1  outputs = latched msg1 or blank.
//    SHOW2  outputs = latched msg2 or blank.
//  Request capture: reqN high on edge k -> latch msgN/blinkN into slot N, set pendN; edge k+1 visible.
//  Priority: src2 > src1 > src0.
//    req2 in IDLE/SHOW1 -> SHOW2 at the same edge. Preempted src1 keeps pend1 and restarts later.
//    req1 during SHOW2 -> pend1 set, shown after SHOW2 ends. Re-req of the shown source reloads data and hold timer.
//    req1 and req2 on the same edge -> SHOW2, pend1=1.
//  Hold: on SHOWn entry hold_cnt=HOLD_T-1. Each tick decrements it.
//    tick with hold_cnt==0 clears pendN and exits.
//    Exit goes to SHOW1 if pend1, else IDLE (same edge).
//  Blink: phase=visible on SHOWn entry. blink_cnt counts ticks; phase toggles every BLINK_T ticks.
//    Blink-off drives BLANK_CODE on all digits. blink=0 -> always visible.
//  A req and a hold expiry on the same edge: the request wins; the timer reloads for the requested slot.
//  tick while IDLE: counters hold. bg_val changes propagate every clk, not just on tick.
//  busy = pend1|pend2 (registered with state). active_src tracks state.
//  clr mid-message: message discarded, outputs 0 until first post-reset edge shows bg_val.
//  Counters width clog2(HOLD_T), clog2(BLINK_T); no wrap beyond reload value.
// STRUCTURE
//  display_defs.vh: state encodings (IDLE/SHOW1/SHOW2), source ids, BLANK_CODE default.
//  Sub-module msg_slot: per-source 16-bit data + blink + pend register with load/clear.
//    Instantiated twice; the scheduler FSM, timers and output mux stay in the top.
// TESTING (HOLD_T=4, BLINK_T=2 in bench)
//  Reset: clr=1 mid-SHOW2 -> d*=0, active_src=0, busy=0; next edge after release shows bg_val.
//  Idle: bg_val=16'h0125 -> d1..d4=0,1,2,5 one clk later, active_src=0; change bg_val -> follows.
//  Hold: req1, msg1=16'h0150, blink1=0 -> d=0150 for exactly 4 ticks, then bg; busy 1->0.
//  Preempt: req1, then req2 (16'h5D1D) after 1 tick -> SHOW2 next clk for 4 ticks, then SHOW1 for full 4 ticks.
//  Simultaneous: req1 and req2 same edge -> active_src=2, busy=1, then 1, then 0.
//  Blink: req2 blink2=1 -> visible 2 ticks, FFFF 2 ticks, visible 2... exits after 4 ticks.
//    Re-req mid-hold reloads timer.

Source files
------------

// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the display scheduler: state encoding, source ids,
// default blank nibble and counter sizing.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW1 = 2'd1,
    ST_SHOW2 = 2'd2
  } state_e;

  localparam logic [1:0] SRC_BG   = 2'd0;
  localparam logic [1:0] SRC_MSG1 = 2'd1;
  localparam logic [1:0] SRC_MSG2 = 2'd2;

  localparam logic [3:0] BLANK_DEFAULT = 4'hF;

  // A counter that reloads to n-1 and never wraps needs clog2(n) bits, but at least one.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] srcOf(input state_e st);
    case (st)
      ST_SHOW1: return SRC_MSG1;
      ST_SHOW2: return SRC_MSG2;
      default:  return SRC_BG;
    endcase
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Request/data inputs and digit outputs of the display scheduler, grouped as one bus.
interface display_scheduler_if;

  logic        tick_i;
  logic [15:0] bg_val_i;
  logic        req1_i;
  logic [15:0] msg1_i;
  logic        blink1_i;
  logic        req2_i;
  logic [15:0] msg2_i;
  logic        blink2_i;
  logic [3:0]  d1_o;
  logic [3:0]  d2_o;
  logic [3:0]  d3_o;
  logic [3:0]  d4_o;
  logic [1:0]  active_src_o;
  logic        busy_o;

  modport master (
    output tick_i, bg_val_i, req1_i, msg1_i, blink1_i, req2_i, msg2_i, blink2_i,
    input  d1_o, d2_o, d3_o, d4_o, active_src_o, busy_o
  );

  modport slave (
    input  tick_i, bg_val_i, req1_i, msg1_i, blink1_i, req2_i, msg2_i, blink2_i,
    output d1_o, d2_o, d3_o, d4_o, active_src_o, busy_o
  );

endinterface

// File: rtl/display_scheduler_msg_slot.sv
// One message slot: latched digits, blink flag and pending flag.
// A load in the same cycle as a clear wins, so a fresh request is never lost.
module display_scheduler_msg_slot (
  input  logic        clk,
  input  logic        clr,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] data_i,
  input  logic        blink_i,
  output logic [15:0] data_o,
  output logic        blink_o,
  output logic        pend_o
);

  logic [15:0] data_q;
  logic        blink_q;
  logic        pend_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q  <= '0;
      blink_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      blink_q <= blink_i;
      pend_q  <= 1'b1;
    end else if (clear_i) begin
      pend_q  <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign blink_o = blink_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/display_scheduler.sv
// Shares a 4-digit display between a background value and two one-shot messages,
// src2 over src1 over background, each message held for HOLD_T ticks with optional blink.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int         HOLD_T     = 2000,
  parameter int         BLINK_T    = 250,
  parameter logic [3:0] BLANK_CODE = BLANK_DEFAULT
) (
  input logic                clk,
  input logic                clr,
  display_scheduler_if.slave bus
);

  localparam int HW = cntWidth(HOLD_T);
  localparam int BW = cntWidth(BLINK_T);

  state_e          state_q, state_d;
  logic [HW-1:0]   holdCnt_q, holdCnt_d;
  logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
  logic            phaseOn_q, phaseOn_d;
  logic [15:0]     digits_q, digits_d;

  logic [15:0]     data1, data2;
  logic            blink1, blink2, pend1, pend2;
  logic            clear1, clear2, reload, advance, expire;

  display_scheduler_msg_slot u_slot1 (
    .clk     (clk),
    .clr     (clr),
    .load_i  (bus.req1_i),
    .clear_i (clear1),
    .data_i  (bus.msg1_i),
    .blink_i (bus.blink1_i),
    .data_o  (data1),
    .blink_o (blink1),
    .pend_o  (pend1)
  );

  display_scheduler_msg_slot u_slot2 (
    .clk     (clk),
    .clr     (clr),
    .load_i  (bus.req2_i),
    .clear_i (clear2),
    .data_i  (bus.msg2_i),
    .blink_i (bus.blink2_i),
    .data_o  (data2),
    .blink_o (blink2),
    .pend_o  (pend2)
  );

  assign expire = bus.tick_i && (state_q != ST_IDLE) && (holdCnt_q == '0);

  // Requests take precedence over an expiry on the same edge; req1 cannot interrupt SHOW2.
  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    blinkCnt_d = blinkCnt_q;
    phaseOn_d  = phaseOn_q;
    clear1     = 1'b0;
    clear2     = 1'b0;
    reload     = 1'b0;
    advance    = 1'b0;

    if (bus.req2_i) begin
      state_d = ST_SHOW2;
      reload  = 1'b1;
    end else if (bus.req1_i && (state_q != ST_SHOW2)) begin
      state_d = ST_SHOW1;
      reload  = 1'b1;
    end else if (expire) begin
      clear1 = (state_q == ST_SHOW1);
      clear2 = (state_q == ST_SHOW2);
      if ((state_q == ST_SHOW2) && (pend1 || bus.req1_i)) begin
        state_d = ST_SHOW1;
        reload  = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (bus.tick_i && (state_q != ST_IDLE)) begin
      advance = 1'b1;
    end

    if (advance) begin
      holdCnt_d = holdCnt_q - HW'(1);
      if (blinkCnt_q == BW'(BLINK_T - 1)) begin
        blinkCnt_d = '0;
        phaseOn_d  = ~phaseOn_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BW'(1);
      end
    end

    if (reload) begin
      holdCnt_d  = HW'(HOLD_T - 1);
      blinkCnt_d = '0;
      phaseOn_d  = 1'b1;
    end
  end

  always_comb begin
    digits_d = bus.bg_val_i;
    case (state_q)
      ST_SHOW1: digits_d = (blink1 && !phaseOn_q) ? {4{BLANK_CODE}} : data1;
      ST_SHOW2: digits_d = (blink2 && !phaseOn_q) ? {4{BLANK_CODE}} : data2;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      holdCnt_q  <= '0;
      blinkCnt_q <= '0;
      phaseOn_q  <= 1'b1;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      blinkCnt_q <= blinkCnt_d;
      phaseOn_q  <= phaseOn_d;
      digits_q   <= digits_d;
    end
  end

  assign bus.d1_o         = digits_q[15:12];
  assign bus.d2_o         = digits_q[11:8];
  assign bus.d3_o         = digits_q[7:4];
  assign bus.d4_o         = digits_q[3:0];
  assign bus.active_src_o = srcOf(state_q);
  assign bus.busy_o       = pend1 | pend2;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: a tick-counting reference model queues the
// expected digits/source/busy for every cycle and a monitor process checks each one.
module tb_display_scheduler;

  localparam int         HOLD_T  = 4;
  localparam int         BLINK_T = 2;
  localparam logic [3:0] BLANK   = 4'hF;

  typedef struct packed {
    logic [15:0] disp;
    logic [1:0]  src;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  exp_t expQ[$];

  // Reference model: which source is on screen and how many ticks it has been shown.
  int          curSrc;
  int          ticksShown;
  logic        pend1, pend2;
  logic [15:0] slotMsg1, slotMsg2;
  logic        slotBlink1, slotBlink2;
  logic [15:0] curBg;

  display_scheduler_if bus();

  display_scheduler #(
    .HOLD_T     (HOLD_T),
    .BLINK_T    (BLINK_T),
    .BLANK_CODE (BLANK)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] modelDisplay();
    logic [15:0] msg;
    logic        bl;
    if (curSrc == 0) return curBg;
    msg = (curSrc == 1) ? slotMsg1 : slotMsg2;
    bl  = (curSrc == 1) ? slotBlink1 : slotBlink2;
    if (bl && ((ticksShown / BLINK_T) % 2 == 1)) return {4{BLANK}};
    return msg;
  endfunction

  task automatic modelReset();
    curSrc     = 0;
    ticksShown = 0;
    pend1      = 1'b0;
    pend2      = 1'b0;
    slotMsg1   = '0;
    slotMsg2   = '0;
    slotBlink1 = 1'b0;
    slotBlink2 = 1'b0;
  endtask

  // Drives one cycle of inputs, predicts the response, then advances to the next negedge.
  task automatic applyStimulus(input logic tick, input logic r1, input logic [15:0] m1, input logic b1,
                               input logic r2, input logic [15:0] m2, input logic b2);
    logic [15:0] dispExp;
    logic        expire;
    exp_t        e;
    bus.tick_i   = tick;
    bus.req1_i   = r1;
    bus.msg1_i   = m1;
    bus.blink1_i = b1;
    bus.req2_i   = r2;
    bus.msg2_i   = m2;
    bus.blink2_i = b2;
    bus.bg_val_i = curBg;

    dispExp = modelDisplay();
    expire  = tick && (curSrc != 0) && (ticksShown == HOLD_T - 1);
    if (r1) begin slotMsg1 = m1; slotBlink1 = b1; pend1 = 1'b1; end
    if (r2) begin slotMsg2 = m2; slotBlink2 = b2; pend2 = 1'b1; end
    if (r2) begin
      curSrc = 2; ticksShown = 0;
    end else if (r1 && curSrc != 2) begin
      curSrc = 1; ticksShown = 0;
    end else if (expire) begin
      if (curSrc == 1) pend1 = 1'b0;
      else pend2 = 1'b0;
      if (curSrc == 2 && pend1) begin
        curSrc = 1; ticksShown = 0;
      end else begin
        curSrc = 0;
      end
    end else if (tick && curSrc != 0) begin
      ticksShown++;
    end

    e.disp = dispExp;
    e.src  = 2'(curSrc);
    e.busy = pend1 | pend2;
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runCycles(input int n, input int tickEvery);
    for (int i = 0; i < n; i++)
      applyStimulus((i % tickEvery) == (tickEvery - 1), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic resetMidway();
    #2 clr = 1'b1;
    #1;
    checkOutput("reset_digits", 32'({bus.d1_o, bus.d2_o, bus.d3_o, bus.d4_o}), 32'h0);
    checkOutput("reset_src", 32'(bus.active_src_o), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy_o), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    modelReset();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("digits", 32'({bus.d1_o, bus.d2_o, bus.d3_o, bus.d4_o}), 32'(e.disp));
        checkOutput("active_src", 32'(bus.active_src_o), 32'(e.src));
        checkOutput("busy", 32'(bus.busy_o), 32'(e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic t, r1, r2;
    curBg        = 16'h0;
    bus.tick_i   = 1'b0;
    bus.req1_i   = 1'b0;
    bus.msg1_i   = '0;
    bus.blink1_i = 1'b0;
    bus.req2_i   = 1'b0;
    bus.msg2_i   = '0;
    bus.blink2_i = 1'b0;
    bus.bg_val_i = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_digits", 32'({bus.d1_o, bus.d2_o, bus.d3_o, bus.d4_o}), 32'h0);
    checkOutput("init_src", 32'(bus.active_src_o), 32'h0);
    checkOutput("init_busy", 32'(bus.busy_o), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // Background follows bg_val every clock.
    curBg = 16'h0125;
    runCycles(3, 2);
    curBg = 16'h0987;
    runCycles(2, 2);

    // Single message held for HOLD_T ticks.
    applyStimulus(1'b0, 1'b1, 16'h0150, 1'b0, 1'b0, 16'h0, 1'b0);
    runCycles(16, 3);

    // src2 preempts src1 after one tick; src1 then gets a full hold.
    applyStimulus(1'b0, 1'b1, 16'h0150, 1'b0, 1'b0, 16'h0, 1'b0);
    runCycles(3, 3);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5D1D, 1'b0);
    runCycles(30, 3);

    // Simultaneous requests.
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h5E55, 1'b0);
    runCycles(20, 2);

    // Blinking message, then a re-request mid-hold reloads the timer.
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5E55, 1'b1);
    runCycles(3, 1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hE220, 1'b1);
    runCycles(8, 1);

    // Reset while SHOW2 is on screen.
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hABCD, 1'b0);
    runCycles(2, 2);
    resetMidway();
    curBg = 16'h4321;
    runCycles(3, 2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) curBg = 16'($urandom);
      t  = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 11) == 0);
      r2 = ($urandom_range(0, 17) == 0);
      applyStimulus(t, r1, 16'($urandom), 1'($urandom_range(0, 1)),
                    r2, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    runCycles(2, 2);

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
